// File: rtl/seg595_out.sv
// Hex 7-segment encoder driving an external 74HC595 over SER/SRCLK/RCLK.
// Retransmits when the displayed value changes or when the refresh interval expires.
module seg595_out #(
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned REFRESH_CYCLES = 1024,
    parameter bit          COMMON_ANODE   = 1'b0
) (
    input  logic       CLK,
    input  logic       n_RST,
    input  logic [3:0] O_IN,
    input  logic       DP,
    input  logic       EN,
    output logic       SER,
    output logic       SRCLK,
    output logic       RCLK,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
    localparam int         RW      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic [7:0] POL     = COMMON_ANODE ? 8'hFF : 8'h00;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    logic [1:0]    state, state_nxt;
    logic [7:0]    div_cnt, div_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [4:0]    last_sent, last_sent_nxt;
    logic          last_vld, last_vld_nxt;
    logic [RW-1:0] ref_cnt, ref_cnt_nxt;
    logic          ref_pend, ref_pend_nxt;
    logic [4:0]    cur;
    logic [7:0]    pat;
    logic          start, div_last, ref_tick, ser_nxt;

    assign cur      = {DP, O_IN};
    assign pat      = {DP, hex_seg(O_IN)} ^ POL;
    assign div_last = (div_cnt == DIV_MAX);
    assign start    = (state == IDLE) && EN && (!last_vld || (cur != last_sent) || ref_pend);
    assign ref_tick = (REFRESH_CYCLES != 0) && (ref_cnt == REF_MAX);

    always_comb begin
        state_nxt     = state;
        div_cnt_nxt   = div_cnt + 8'd1;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        last_sent_nxt = last_sent;
        last_vld_nxt  = last_vld;
        case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                if (start) begin
                    state_nxt     = SHIFT_LO;
                    shreg_nxt     = pat;
                    last_sent_nxt = cur;
                    last_vld_nxt  = 1'b1;
                    bit_idx_nxt   = 3'd7;
                end
            end
            SHIFT_LO: if (div_last) begin
                state_nxt   = SHIFT_HI;
                div_cnt_nxt = '0;
            end
            SHIFT_HI: if (div_last) begin
                div_cnt_nxt = '0;
                if (bit_idx == 3'd0) begin
                    state_nxt = LATCH;
                end else begin
                    state_nxt   = SHIFT_LO;
                    bit_idx_nxt = bit_idx - 3'd1;
                end
            end
            default: if (div_last) begin
                state_nxt   = IDLE;
                div_cnt_nxt = '0;
            end
        endcase
        ser_nxt = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) && shreg_nxt[bit_idx_nxt];
    end

    // A transfer start absorbs a refresh tick landing on the same edge.
    always_comb begin
        ref_cnt_nxt  = (REFRESH_CYCLES == 0 || ref_tick) ? '0 : ref_cnt + RW'(1);
        ref_pend_nxt = ref_pend;
        if (start)         ref_pend_nxt = 1'b0;
        else if (ref_tick) ref_pend_nxt = 1'b1;
    end

    // Pin outputs are registered from the next state so the 595 never sees decode glitches.
    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            last_sent <= '0;
            last_vld  <= 1'b0;
            ref_cnt   <= '0;
            ref_pend  <= 1'b0;
            SER       <= 1'b0;
            SRCLK     <= 1'b0;
            RCLK      <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            last_sent <= last_sent_nxt;
            last_vld  <= last_vld_nxt;
            ref_cnt   <= ref_cnt_nxt;
            ref_pend  <= ref_pend_nxt;
            SER       <= ser_nxt;
            SRCLK     <= (state_nxt == SHIFT_HI);
            RCLK      <= (state_nxt == LATCH);
            BUSY      <= (state_nxt != IDLE);
            DONE      <= (state == LATCH) && div_last;
        end
    end

endmodule

// File: doc/seg595_out.md
Name: seg595_out

Overview:
- Output stage downstream of the main Logisim circuit. Consumes its 4-bit result O[3:0] plus a decimal-point bit.
- Encodes the value as a hex 7-segment pattern.
- Shifts the pattern serially into an external 74HC595 through three io_out pins.
- Lets a single TT02 output pin group drive a full digit. Retransmits on value change or periodic refresh.

Parameters:
- CLK_DIV, 2: CLK cycles per SRCLK half-period. Legal range 1..255.
- REFRESH_CYCLES, 1024: CLK cycles between forced retransmissions. 0 disables refresh.
- COMMON_ANODE, 0: 1 inverts all 8 pattern bits before shifting.

Ports:
- CLK  input  1  system clock.
- n_RST  input  1  asynchronous active-low reset.
- O_IN  input  4  value from the main circuit (O_3..O_0), sampled synchronously.
- DP  input  1  decimal-point request.
- EN  input  1  transfer enable. Level-sensitive.
- SER  output  1  serial data to 595 SER.
- SRCLK  output  1  shift clock to 595.
- RCLK  output  1  storage/latch clock to 595.
- BUSY  output  1  high while a transfer is in progress.
- DONE  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (n_RST low, asynchronous):
  - SER, SRCLK, RCLK, BUSY and DONE are all 0.
  - FSM enters IDLE.
  - Refresh counter is 0.
  - last_sent is marked invalid, so the first transfer after reset is forced.
- Pattern is 8 bits, {dp,g,f,e,d,c,b,a}, with bit7 = DP.
- Hex table, segment bits [6:0]: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- The byte is XORed with 0xFF when COMMON_ANODE=1.
- States are IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - Start condition: EN=1 and any of:
    - last_sent invalid;
    - {DP,O_IN} differs from last_sent;
    - refresh pending.
  - On the start edge: snapshot {DP,O_IN} into a shift register and into last_sent. Clear refresh pending. Set bit index to 7. Go to SHIFT_LO.
- SHIFT_LO:
  - SER = pattern[bit index], SRCLK = 0, for CLK_DIV cycles.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - SRCLK = 1 and SER is held, for CLK_DIV cycles.
  - Then: if bit index = 0, go to LATCH; otherwise decrement the index and return to SHIFT_LO.
  - MSB is shifted first.
- LATCH:
  - RCLK = 1, SRCLK = 0, for CLK_DIV cycles.
  - Then go to IDLE and assert DONE for exactly 1 cycle.
- Timing: with the start edge at cycle t, with N = CLK_DIV:
  - BUSY is 1 from t+1 through t+17N.
  - Bit k (k=0 for bit7) has its SRCLK rising edge at t+1+(2k+1)N.
  - RCLK is high over t+1+16N .. t+16N+N.
  - DONE is high at t+1+17N.
- Outside SHIFT/LATCH: SRCLK = RCLK = 0 and SER = 0.
- Input changes mid-transfer do not alter the transfer in flight. The change is detected in IDLE and starts a new transfer on the cycle after DONE.
- Refresh counter:
  - Counts every CLK cycle.
  - When it reaches REFRESH_CYCLES-1, it sets refresh pending and wraps to 0.
  - Pending is sticky until a transfer starts.
  - With REFRESH_CYCLES=0 the counter is held at 0 and pending is never set.
- EN=0:
  - No new transfer starts.
  - A transfer in flight always completes.
  - Pending flags and change detection are retained.
- Simultaneous change and refresh produce a single transfer.
- Reset asserted mid-transfer aborts the transfer at once. All outputs go to 0 and no DONE is produced.

Test Plan:
- Reset release, EN=1, O_IN=0, DP=0, CLK_DIV=2: SER bits sampled at SRCLK rises are 0,0,1,1,1,1,1,1 (0x3F). RCLK high for 2 cycles. DONE at start+35. BUSY high for 34 cycles. No further transfer while input is static and REFRESH_CYCLES=0.
- After the first transfer, set O_IN=0xA, DP=1: one transfer shifting 0xF7. With COMMON_ANODE=1, the same stimulus shifts 0x08.
- Change O_IN from 3 to 5 at the 3rd SRCLK rise of a transfer: that transfer completes with 0x4F. The next start occurs the cycle after DONE and shifts 0x6D.
- REFRESH_CYCLES=64, input static, EN=1: a transfer with an identical byte starts every 64 cycles, delayed to the cycle after DONE if pending arrives mid-transfer. Hold EN=0 for 200 cycles: no transfers. Raise EN: exactly one transfer starts on the next cycle.
- Assert n_RST during bit 4: SER/SRCLK/RCLK/BUSY go to 0 asynchronously and no DONE is produced. After release, a full transfer of the current value starts even though the value is unchanged.
- All 16 O_IN values at DP=0: the shifted byte matches the hex table for every value.
